// File: rtl/bsg_fpu_pkg.sv
// Shared FPU definitions: rounding-mode encoding, exception flag bundle and
// canonical constant encodings (quiet NaN, infinity, largest finite value).
// The constant functions return 64-bit values. The caller keeps the low
// e_p+m_p+1 bits.
package bsg_fpu_pkg;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } bsg_fpu_rm_e;

  typedef struct packed {
    logic nv;     // invalid operation
    logic of;     // overflow
    logic uf;     // underflow (tiny result flushed to zero)
    logic nx;     // inexact
    logic unimp;  // unsupported mode or operand
  } bsg_fpu_eflags_s;

  // Positive quiet NaN: exponent all ones, mantissa MSB set.
  function automatic logic [63:0] bsg_fpu_qnan(input int e_p, input int m_p);
    return ((64'd1 << (e_p + 1)) - 64'd1) << (m_p - 1);
  endfunction

  // Positive infinity: exponent all ones, mantissa zero.
  function automatic logic [63:0] bsg_fpu_inf(input int e_p, input int m_p);
    return ((64'd1 << e_p) - 64'd1) << m_p;
  endfunction

  // Largest positive finite value. This is the bit pattern just below +inf.
  function automatic logic [63:0] bsg_fpu_max(input int e_p, input int m_p);
    return bsg_fpu_inf(e_p, m_p) - 64'd1;
  endfunction

endpackage

// File: rtl/bsg_fpu_round.sv
// Combinational rounder shared by the FP adder and multiplier.
// Inputs : sign_i, biased exponent exp_i (one spare MSB), fraction man_i
//          (no hidden bit), guard g_i, sticky s_i, rounding mode rm_i.
// Outputs: rounded {exp_o, man_o}. A fraction carry ripples into exp_o.
//          of_o is set when the rounded exponent reaches all-ones.
//          sat_o is the signed result to use on overflow for this mode.
//          nx_o is set when any bit below the LSB was non-zero.
module bsg_fpu_round
  import bsg_fpu_pkg::*;
#(
  parameter int e_p = 8,
  parameter int m_p = 23
) (
  input  logic             sign_i,
  input  logic [e_p:0]     exp_i,
  input  logic [m_p-1:0]   man_i,
  input  logic             g_i,
  input  logic             s_i,
  input  logic [2:0]       rm_i,
  output logic [e_p:0]     exp_o,
  output logic [m_p-1:0]   man_o,
  output logic             of_o,
  output logic [e_p+m_p:0] sat_o,
  output logic             nx_o
);

  localparam logic [63:0] inf_lp = bsg_fpu_inf(e_p, m_p);
  localparam logic [63:0] max_lp = bsg_fpu_max(e_p, m_p);

  logic                 inc;
  logic [e_p+m_p-1:0]   sat_mag;

  always_comb begin
    inc     = 1'b0;
    sat_mag = inf_lp[e_p+m_p-1:0];
    case (bsg_fpu_rm_e'(rm_i))
      RNE: inc = g_i & (s_i | man_i[0]);
      RTZ: begin
        inc     = 1'b0;
        sat_mag = max_lp[e_p+m_p-1:0];
      end
      RDN: begin
        inc     = sign_i & (g_i | s_i);
        sat_mag = sign_i ? inf_lp[e_p+m_p-1:0] : max_lp[e_p+m_p-1:0];
      end
      RUP: begin
        inc     = ~sign_i & (g_i | s_i);
        sat_mag = sign_i ? max_lp[e_p+m_p-1:0] : inf_lp[e_p+m_p-1:0];
      end
      RMM: inc = g_i;
      default: inc = 1'b0;
    endcase
  end

  // Exponent and fraction are incremented as one word, so a fraction carry
  // bumps the exponent.
  assign {exp_o, man_o} = {exp_i, man_i} + (e_p + m_p + 1)'(inc);
  assign of_o  = (exp_o >= {1'b0, {e_p{1'b1}}});
  assign sat_o = {sign_i, sat_mag};
  assign nx_o  = g_i | s_i;

endmodule

// File: rtl/bsg_fpu_add_sub_rm.sv
// Three-stage floating-point adder/subtractor with dynamic rounding mode.
// Stage 1: classify operands, select the larger magnitude, align the
//          smaller operand with guard/round/sticky bits, and resolve special
//          results.
// Stage 2: add or subtract the mantissas.
// Stage 3: normalise, round, and pick the result by priority.
// Ports: clk_i/reset_i (sync, active high), en_i global enable,
//        v_i/ready_o input handshake, a_i/b_i/sub_i/rm_i/tag_i operation,
//        v_o/yumi_i output handshake, z_o/tag_o result, and flags
//        unimplemented_o, invalid_o, overflow_o, underflow_o, inexact_o.
// Handshake: an input transfers when v_i & ready_o at a rising edge. A result
// leaves when v_o & yumi_i & en_i. A held result (v_o & ~yumi_i) or en_i=0
// freezes all three stages together, and ready_o drops.
module bsg_fpu_add_sub_rm
  import bsg_fpu_pkg::*;
#(
  parameter int e_p         = 8,
  parameter int m_p         = 23,
  parameter int tag_width_p = 4,
  parameter bit ftz_p       = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   en_i,
  input  logic                   v_i,
  input  logic [e_p+m_p:0]       a_i,
  input  logic [e_p+m_p:0]       b_i,
  input  logic                   sub_i,
  input  logic [2:0]             rm_i,
  input  logic [tag_width_p-1:0] tag_i,
  output logic                   ready_o,
  output logic                   v_o,
  output logic [e_p+m_p:0]       z_o,
  output logic [tag_width_p-1:0] tag_o,
  output logic                   unimplemented_o,
  output logic                   invalid_o,
  output logic                   overflow_o,
  output logic                   underflow_o,
  output logic                   inexact_o,
  input  logic                   yumi_i
);

  localparam int w_lp   = e_p + m_p + 1;
  localparam int aw_lp  = m_p + 4;   // hidden bit + fraction + G/R/S
  localparam int sw_lp  = m_p + 5;   // aligned width + carry
  localparam int lzw_lp = $clog2(sw_lp + 1);
  localparam logic [63:0] qnan_lp = bsg_fpu_qnan(e_p, m_p);
  localparam logic [63:0] inf_lp  = bsg_fpu_inf(e_p, m_p);

  logic v_1, v_2, v_3, stall, advance;
  assign stall   = v_3 & ~yumi_i;
  assign advance = ~stall & en_i;
  assign ready_o = advance;
  assign v_o     = v_3;

  // ---------------- stage 1: classify and align ----------------
  logic             sa, sb, eff_sub, a_ge;
  logic [e_p-1:0]   ea, eb, e_l, e_s, diff;
  logic [m_p-1:0]   fa, fb;
  logic             a_ez, b_ez, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_den, b_den;
  logic [e_p+m_p-1:0] a_mag, b_mag;
  logic [m_p:0]     m_a, m_b, m_l, m_s;
  logic [2*aw_lp-1:0] sh;
  logic [aw_lp-1:0] aligned;

  assign sa = a_i[w_lp-1];
  assign sb = b_i[w_lp-1] ^ sub_i;   // effective sign of B
  assign ea = a_i[w_lp-2 -: e_p];
  assign eb = b_i[w_lp-2 -: e_p];
  assign fa = a_i[m_p-1:0];
  assign fb = b_i[m_p-1:0];

  assign a_ez   = (ea == '0);
  assign b_ez   = (eb == '0);
  assign a_nan  = (&ea) & (|fa);
  assign b_nan  = (&eb) & (|fb);
  assign a_snan = a_nan & ~fa[m_p-1];
  assign b_snan = b_nan & ~fb[m_p-1];
  assign a_inf  = (&ea) & ~(|fa);
  assign b_inf  = (&eb) & ~(|fb);
  assign a_den  = a_ez & (|fa);
  assign b_den  = b_ez & (|fb);

  // Denormals enter the datapath as zero. When they are not flushed, the
  // special-case logic below overrides the result anyway.
  assign a_mag   = a_ez ? '0 : a_i[w_lp-2:0];
  assign b_mag   = b_ez ? '0 : b_i[w_lp-2:0];
  assign m_a     = a_ez ? '0 : {1'b1, fa};
  assign m_b     = b_ez ? '0 : {1'b1, fb};
  assign a_ge    = (a_mag >= b_mag);
  assign eff_sub = sa ^ sb;

  always_comb begin
    e_l  = a_ge ? ea : eb;
    e_s  = a_ge ? eb : ea;
    m_l  = a_ge ? m_a : m_b;
    m_s  = a_ge ? m_b : m_a;
    diff = e_l - e_s;
    sh   = {m_s, 3'b000, {aw_lp{1'b0}}} >> diff;
    // Beyond the aligned width the whole operand collapses into sticky.
    if (int'(diff) >= aw_lp) aligned = {{(aw_lp-1){1'b0}}, |m_s};
    else                     aligned = {sh[2*aw_lp-1:aw_lp+1], sh[aw_lp] | (|sh[aw_lp-1:0])};
  end

  logic            spec;
  logic [w_lp-1:0] spec_z;
  bsg_fpu_eflags_s spec_f;

  always_comb begin
    spec   = 1'b1;
    spec_z = qnan_lp[w_lp-1:0];
    spec_f = '0;
    if (a_snan | b_snan)                         spec_f.nv = 1'b1;
    else if (a_nan | b_nan)                      spec_f    = '0;
    else if (a_inf & b_inf & eff_sub)            spec_f.nv = 1'b1;
    else if (a_inf | b_inf)                      spec_z    = {a_inf ? sa : sb, inf_lp[w_lp-2:0]};
    else if (rm_i > 3'd4)                        spec_f.unimp = 1'b1;
    else if (!ftz_p && (a_den | b_den))          spec_f.unimp = 1'b1;
    else                                         spec = 1'b0;
  end

  logic                   s1_eff_sub, s1_sign, s1_zsign, s1_spec;
  logic [e_p-1:0]         s1_el;
  logic [aw_lp-1:0]       s1_ml, s1_ms;
  logic [w_lp-1:0]        s1_spec_z;
  bsg_fpu_eflags_s        s1_spec_f;
  logic [2:0]             s1_rm;
  logic [tag_width_p-1:0] s1_tag;

  // ---------------- stage 2: mantissa add/subtract ----------------
  logic [sw_lp-1:0]       sum;
  assign sum = s1_eff_sub ? ({1'b0, s1_ml} - {1'b0, s1_ms}) : ({1'b0, s1_ml} + {1'b0, s1_ms});

  logic                   s2_sign, s2_zsign, s2_spec;
  logic [e_p-1:0]         s2_el;
  logic [sw_lp-1:0]       s2_sum;
  logic [w_lp-1:0]        s2_spec_z;
  bsg_fpu_eflags_s        s2_spec_f;
  logic [2:0]             s2_rm;
  logic [tag_width_p-1:0] s2_tag;

  // Payload registers: they load only with a valid beat and need no reset.
  always_ff @(posedge clk_i) begin
    if (advance && v_i) begin
      s1_eff_sub <= eff_sub;
      s1_sign    <= a_ge ? sa : sb;
      // An exact zero keeps a shared sign. Opposite signs give +0, or -0 in RDN.
      s1_zsign   <= eff_sub ? (bsg_fpu_rm_e'(rm_i) == RDN) : sa;
      s1_el      <= e_l;
      s1_ml      <= {m_l, 3'b000};
      s1_ms      <= aligned;
      s1_spec    <= spec;
      s1_spec_z  <= spec_z;
      s1_spec_f  <= spec_f;
      s1_rm      <= rm_i;
      s1_tag     <= tag_i;
    end
    if (advance && v_1) begin
      s2_sign   <= s1_sign;
      s2_zsign  <= s1_zsign;
      s2_el     <= s1_el;
      s2_sum    <= sum;
      s2_spec   <= s1_spec;
      s2_spec_z <= s1_spec_z;
      s2_spec_f <= s1_spec_f;
      s2_rm     <= s1_rm;
      s2_tag    <= s1_tag;
    end
  end

  // ---------------- stage 3: normalise, round, select ----------------
  logic [lzw_lp-1:0] lz;
  logic [sw_lp-1:0]  norm;
  logic [e_p+1:0]    en;
  logic              uf;

  always_comb begin
    lz = lzw_lp'(sw_lp);
    for (int i = 0; i < sw_lp; i++) begin
      if (s2_sum[i]) lz = lzw_lp'(sw_lp - 1 - i);
    end
  end

  // The sum's MSB is the carry position, so the exponent is el + 1 - lz.
  // A negative or zero exponent means the result is too small to represent.
  assign norm = s2_sum << lz;
  assign en   = {2'b00, s2_el} + (e_p + 2)'(1) - (e_p + 2)'(lz);
  assign uf   = en[e_p+1] | (en == '0);

  logic [e_p:0]     rnd_exp;
  logic [m_p-1:0]   rnd_man;
  logic             rnd_of, rnd_nx;
  logic [w_lp-1:0]  rnd_sat;

  bsg_fpu_round #(.e_p(e_p), .m_p(m_p)) round (
    .sign_i (s2_sign),
    .exp_i  (en[e_p:0]),
    .man_i  (norm[sw_lp-2:4]),
    .g_i    (norm[3]),
    .s_i    (|norm[2:0]),
    .rm_i   (s2_rm),
    .exp_o  (rnd_exp),
    .man_o  (rnd_man),
    .of_o   (rnd_of),
    .sat_o  (rnd_sat),
    .nx_o   (rnd_nx)
  );

  logic [w_lp-1:0] z_n;
  bsg_fpu_eflags_s f_n;

  always_comb begin
    z_n    = {s2_sign, rnd_exp[e_p-1:0], rnd_man};
    f_n    = '0;
    f_n.nx = rnd_nx;
    if (s2_spec) begin
      z_n = s2_spec_z;
      f_n = s2_spec_f;
    end else if (s2_sum == '0) begin
      z_n = {s2_zsign, {(w_lp-1){1'b0}}};
      f_n = '0;
    end else if (uf) begin
      z_n    = {s2_sign, {(w_lp-1){1'b0}}};
      f_n.uf = 1'b1;
      f_n.nx = 1'b1;
    end else if (rnd_of) begin
      z_n    = rnd_sat;
      f_n.of = 1'b1;
      f_n.nx = 1'b1;
    end
  end

  bsg_fpu_eflags_s s3_f;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_1   <= 1'b0;
      v_2   <= 1'b0;
      v_3   <= 1'b0;
      z_o   <= '0;
      tag_o <= '0;
      s3_f  <= '0;
    end else if (advance) begin
      v_1 <= v_i;
      v_2 <= v_1;
      v_3 <= v_2;
      if (v_2) begin
        z_o   <= z_n;
        tag_o <= s2_tag;
        s3_f  <= f_n;
      end
    end
  end

  assign invalid_o       = s3_f.nv;
  assign overflow_o      = s3_f.of;
  assign underflow_o     = s3_f.uf;
  assign inexact_o       = s3_f.nx;
  assign unimplemented_o = s3_f.unimp;

endmodule

// File: doc/bsg_fpu_add_sub_rm.md
Name: bsg_fpu_add_sub_rm

Overview:
Parameterised IEEE-754-style floating-point adder/subtractor with a 3-stage valid/yumi pipeline.
- Adds per-operation dynamic rounding modes: RNE, RTZ, RDN, RUP, RMM.
- Adds an inexact flag, a tag passthrough, and optional flush-to-zero of denormal inputs.
- Sits in the FPU datapath beside the multiplier; feeds the FP result arbiter.

Parameters:
e_p, 8, exponent width
m_p, 23, mantissa width (no hidden bit)
tag_width_p, 4, width of opaque tag carried with each operation
ftz_p, 1, 1 = denormal inputs treated as signed zero; 0 = denormal input raises unimplemented_o

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
en_i  in  1  global pipeline enable
v_i  in  1  input valid
a_i  in  e_p+m_p+1  operand A
b_i  in  e_p+m_p+1  operand B
sub_i  in  1  1 = A-B, 0 = A+B
rm_i  in  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM
tag_i  in  tag_width_p  tag, returned unchanged with the result
ready_o  out  1  input accepted when v_i & ready_o
v_o  out  1  result valid
z_o  out  e_p+m_p+1  result
tag_o  out  tag_width_p  tag of the current result
unimplemented_o  out  1  unsupported rm_i, or denormal input with ftz_p=0
invalid_o  out  1  signalling NaN input, or inf-inf
overflow_o  out  1  result exponent overflow
underflow_o  out  1  tiny non-zero result flushed
inexact_o  out  1  rounded result differs from exact result
yumi_i  in  1  consumer takes result; only legal when v_o & en_i

Behaviour:
- Clock, reset and handshake:
  - One clock clk_i. reset_i is synchronous, active-high.
  - Reset clears v_1/v_2/v_3 and all stage-3 payload registers. After reset: v_o=0, z_o=+0, tag_o=0, all flags 0.
  - stall = v_o & ~yumi_i. ready_o = ~stall & en_i.
  - All stages advance together when ~stall & en_i. Payload registers load only when the upstream valid is set.
  - Latency is 3 cycles with no stall. Throughput is 1 op/cycle. No ops are dropped or reordered under stall.
- Stage 1:
  - Classify operands; FTZ denormals to signed zero when ftz_p=1.
  - Compute exponent difference and align the smaller mantissa to m_p+4 bits (guard, round, sticky; sticky is the OR of shifted-out bits).
  - Compute effective op (sub_i^sa^sb) and result sign from a magnitude compare.
  - Register rm_i and tag_i.
- Stage 2: mantissa add/subtract of larger minus/plus smaller magnitude, m_p+5 bit result.
- Stage 3:
  - Leading-zero normalise and adjust exponent, with borrow-out meaning underflow.
  - Round per mode. L = result LSB, G = guard, S = OR of remaining bits.
  - Rounding increments: RNE = G&(S|L); RTZ = 0; RDN = sign&(G|S); RUP = ~sign&(G|S); RMM = G.
  - inexact = G|S.
  - A mantissa carry from rounding increments the exponent.
  - Overflow (exponent all-ones after rounding): overflow_o=1, inexact_o=1.
    - RNE/RMM give ±inf.
    - RTZ gives ±max-finite.
    - RDN gives +max-finite for positive, -inf for negative.
    - RUP gives +inf for positive, -max-finite for negative.
  - Underflow (exponent 0 after rounding, or borrow): signed zero, underflow_o=1, inexact_o=1. No denormal outputs.
  - Exact zero sum:
    - Operands of equal sign keep that sign.
    - Otherwise the result is +0, except RDN gives -0.
- Priority (highest first):
  1. sNaN: qNaN, invalid.
  2. qNaN: qNaN.
  3. inf-inf (effective sub): qNaN, invalid.
  4. Single or same-sign inf: signed inf.
  5. rm_i>4: qNaN, unimplemented.
  6. Denormal with ftz_p=0: qNaN, unimplemented.
  7. Zero / underflow / overflow / normal.
- Special results (1-5) report inexact_o=0. A denormal flushed by FTZ does not by itself set inexact_o.
- Reset mid-operation: all in-flight ops are discarded; v_o=0 in the cycle after reset is sampled.
- en_i=0 freezes every register, including valids. yumi_i is ignored when en_i=0.

Decomposition:
- Package bsg_fpu_pkg holds:
  - the rounding-mode enum bsg_fpu_rm_e (RNE..RMM);
  - the flag struct bsg_fpu_eflags_s (nv, of, uf, nx, unimp);
  - the canonical qNaN/inf/max-finite constant functions of (e_p, m_p).
- Sub-module bsg_fpu_round: combinational. Inputs are sign, exponent, mantissa with G/S, and rm. Outputs are the rounded {exp, man}, overflow saturation value, and inexact. It is reusable by the multiplier.

Test Plan:
- fp32, RNE: 0x3F800000+0x3F800000, v_i one cycle, yumi_i=1 -> v_o exactly 3 cycles later, z_o=0x40000000, all flags 0, tag_o = tag_i.
- 0x3F800000+0x33800000 (halfway case) -> RNE gives 0x3F800000 with inexact; RUP gives 0x3F800001 with inexact; RTZ and RDN give 0x3F800000 with inexact.
- 0x7F7FFFFF+0x7F7FFFFF -> RNE gives 0x7F800000 with overflow|inexact; RTZ gives 0x7F7FFFFF with overflow|inexact. Subtract form with negated operands under RDN gives 0xFF800000.
- 0x3F800000-0x3F800000 -> RNE gives 0x00000000; RDN gives 0x80000000; no flags. 0x7F800000-0x7F800000 gives qNaN with invalid. rm_i=6 gives qNaN with unimplemented.
- 6 back-to-back ops with distinct tags, yumi_i low for 5 cycles after the first result -> ready_o low while stalled, all 6 results delivered in order with correct tags, no duplicates.
- Reset asserted with 2 ops in flight -> v_o=0 and z_o=0 the next cycle; a new op afterwards completes in 3 cycles. With ftz_p=1, 0x00000001+0x3F800000 gives 0x3F800000 and no flags.
